// File: rtl/psum_drain_truah.sv
// Read-out of one captured accumulator column, streamed one word per valid/ready handshake
// with approximated LSBs cleaned and signed saturation to OUT_W. Option: PSUM_DRAIN_MIDPOINT_EN.
module psum_drain_truah #(
    parameter int N_ROWS   = 8,
    parameter int OC_W     = 16,
    parameter int OUT_W    = 16,
    parameter int A_APPROX = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_clear,
    input  logic                   i_load,
    input  logic [N_ROWS*OC_W-1:0] i_psums,
    output logic                   o_busy,
    output logic [OUT_W-1:0]       o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic                   o_overrun
);

    localparam int CNT_W = $clog2(N_ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N_ROWS - 1);
    localparam logic [OC_W-1:0]  LSB_MASK = (OC_W'(1) << A_APPROX) - OC_W'(1);
`ifdef PSUM_DRAIN_MIDPOINT_EN
    localparam logic [OC_W-1:0]  FILL = (LSB_MASK + OC_W'(1)) >> 1;
`else
    localparam logic [OC_W-1:0]  FILL = '0;
`endif

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             capture;
    logic [OC_W-1:0]  buf_q [N_ROWS];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            for (int r = 0; r < N_ROWS; r++) buf_q[r] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            if (capture) begin
                for (int r = 0; r < N_ROWS; r++) buf_q[r] <= i_psums[r*OC_W +: OC_W];
            end
        end
    end

    // A word transfers on the rising edge where o_valid && i_ready; once raised,
    // o_valid holds and o_data/o_last stay stable until that transfer happens.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        if (i_clear) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_load) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (i_load) overrun_d = 1'b1;
                    if (i_ready) begin
                        if (cnt_q == LAST_ROW) begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic [OC_W-1:0]  word;
    logic [OC_W-1:0]  cleaned;
    logic [OUT_W-1:0] sat;

    assign word    = buf_q[cnt_q];
    // Replacing only the low bits means no carry can reach the MSBs.
    assign cleaned = (word & ~LSB_MASK) | FILL;

    generate
        if (OUT_W < OC_W) begin : g_sat
            logic [OC_W-OUT_W:0] top_bits;
            assign top_bits = cleaned[OC_W-1:OUT_W-1];
            always_comb begin
                if (top_bits == '0 || top_bits == '1) sat = cleaned[OUT_W-1:0];
                else if (cleaned[OC_W-1])             sat = {1'b1, {(OUT_W-1){1'b0}}};
                else                                  sat = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end else begin : g_pass
            assign sat = cleaned[OUT_W-1:0];
        end
    endgenerate

    assign o_valid   = (state_q == S_SHIFT);
    assign o_busy    = o_valid;
    assign o_last    = o_valid && (cnt_q == LAST_ROW);
    assign o_overrun = overrun_q;
    // Gated so o_data reads 0 whenever nothing is offered, midpoint fill included.
    assign o_data    = o_valid ? sat : '0;

endmodule

// File: tb/tb_psum_drain_truah.sv
// Bench for psum_drain_truah: three 4-row instances (exact 16b, saturating to 8b,
// 2 approximated LSBs) share stimulus; a negedge monitor checks each against its queue.
module tb_psum_drain_truah;

    logic        clk, rstn, clear, load, ready;
    logic [63:0] psums;

    logic        busy_a, valid_a, last_a, ovr_a;
    logic        busy_b, valid_b, last_b, ovr_b;
    logic        busy_c, valid_c, last_c, ovr_c;
    logic [15:0] data_a, data_c;
    logic [7:0]  data_b;

    logic        v   [3];
    logic        bsy [3];
    logic        lst [3];
    logic        ovr [3];
    logic [15:0] dat [3];

    logic [16:0] exp_q [3][$];
    int          tests_run = 0;
    int          tests_failed = 0;

    psum_drain_truah #(.N_ROWS(4), .OC_W(16), .OUT_W(16), .A_APPROX(0)) u_exact (
        .i_clk(clk), .i_rstn(rstn), .i_clear(clear), .i_load(load), .i_psums(psums),
        .o_busy(busy_a), .o_data(data_a), .o_valid(valid_a), .i_ready(ready),
        .o_last(last_a), .o_overrun(ovr_a));

    psum_drain_truah #(.N_ROWS(4), .OC_W(16), .OUT_W(8), .A_APPROX(0)) u_sat (
        .i_clk(clk), .i_rstn(rstn), .i_clear(clear), .i_load(load), .i_psums(psums),
        .o_busy(busy_b), .o_data(data_b), .o_valid(valid_b), .i_ready(ready),
        .o_last(last_b), .o_overrun(ovr_b));

    psum_drain_truah #(.N_ROWS(4), .OC_W(16), .OUT_W(16), .A_APPROX(2)) u_trunc (
        .i_clk(clk), .i_rstn(rstn), .i_clear(clear), .i_load(load), .i_psums(psums),
        .o_busy(busy_c), .o_data(data_c), .o_valid(valid_c), .i_ready(ready),
        .o_last(last_c), .o_overrun(ovr_c));

    assign v[0] = valid_a;  assign v[1] = valid_b;  assign v[2] = valid_c;
    assign bsy[0] = busy_a; assign bsy[1] = busy_b; assign bsy[2] = busy_c;
    assign lst[0] = last_a; assign lst[1] = last_b; assign lst[2] = last_c;
    assign ovr[0] = ovr_a;  assign ovr[1] = ovr_b;  assign ovr[2] = ovr_c;
    assign dat[0] = data_a; assign dat[1] = {8'h00, data_b}; assign dat[2] = data_c;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- expected-value helpers ----------------
    function automatic logic [15:0] exp_b(input logic [15:0] w);
        int s;
        s = int'($signed(w));
        if (s > 127)  return 16'h007F;
        if (s < -128) return 16'h0080;
        return {8'h00, w[7:0]};
    endfunction

    function automatic logic [15:0] exp_c(input logic [15:0] w);
`ifdef PSUM_DRAIN_MIDPOINT_EN
        return {w[15:2], 2'b10};
`else
        return {w[15:2], 2'b00};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_quiet(input string tag, input logic ovr_req);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_valid%0d", tag, k), 32'(v[k]), 32'd0);
            check($sformatf("%s_busy%0d", tag, k), 32'(bsy[k]), 32'd0);
            check($sformatf("%s_last%0d", tag, k), 32'(lst[k]), 32'd0);
            check($sformatf("%s_data%0d", tag, k), 32'(dat[k]), 32'd0);
            check($sformatf("%s_ovr%0d", tag, k), 32'(ovr[k]), 32'(ovr_req));
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) exp_q[k].delete();
    endtask

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic load_col(input logic [63:0] col);
        logic [15:0] w;
        for (int r = 0; r < 4; r++) begin
            w = col[r*16 +: 16];
            exp_q[0].push_back({r == 3, w});
            exp_q[1].push_back({r == 3, exp_b(w)});
            exp_q[2].push_back({r == 3, exp_c(w)});
        end
        psums = col;
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [15:0] pat, input int n, input int cyc_req);
        bit done = 1'b0;
        int cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            ready = (i < n) ? pat[i] : 1'b1;
            @(posedge clk); #1;
            cycles++;
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 && !valid_a)
                done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, 32'(cycles), 32'(cyc_req));
        check_quiet(tag, 1'b0);
        flush();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 3; k++) begin
                if (v[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("mon%0d_unexpected", k), {15'd0, lst[k], dat[k]}, 32'h1_FFFF);
                    end else if (ready) begin
                        check($sformatf("mon%0d_word", k), {15'd0, lst[k], dat[k]},
                              {15'd0, exp_q[k].pop_front()});
                    end else begin
                        check($sformatf("mon%0d_stall", k), {15'd0, lst[k], dat[k]},
                              {15'd0, exp_q[k][0]});
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit hit_last;
        rstn = 1'b0; clear = 1'b0; load = 1'b0; ready = 1'b0; psums = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset", 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Plain drain, then a stalled drain of the same column.
        ready = 1'b1;
        load_col({16'd4, 16'd3, 16'd2, 16'd1});
        drain("t1", 16'h0000, 0, 4);
        load_col({16'd4, 16'd3, 16'd2, 16'd1});
        drain("t2", 16'b1011001, 7, 7);

        // Saturation and cleaning vectors.
        load_col({16'hFFF0, 16'h0042, 16'hFE00, 16'h0123});
        drain("t3", 16'h0000, 0, 4);
        load_col({16'hFF81, 16'h7FFF, 16'h8000, 16'h00FF});
        drain("t4", 16'h0000, 0, 4);

        // Overrun during row 1, then clear.
        ready = 1'b1;
        load_col({16'd4, 16'd3, 16'd2, 16'd1});
        @(posedge clk); #1;
        load  = 1'b1;
        psums = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge clk); #1;
        load  = 1'b0;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t5_ovr%0d", k), 32'(ovr[k]), 32'd1);
            check($sformatf("t5_valid%0d", k), 32'(v[k]), 32'd1);
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        flush();
        check_quiet("t5_clear", 1'b0);

        // Load arriving on the final-handshake cycle is ignored but flagged.
        ready = 1'b1;
        load_col({16'd40, 16'd30, 16'd20, 16'd10});
        hit_last = 1'b0;
        for (int i = 0; i < 10 && !hit_last; i++) begin
            if (last_a) hit_last = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("t5b_reached_last", 32'(hit_last), 32'd1);
        load  = 1'b1;
        psums = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        load  = 1'b0;
        check_quiet("t5b_ignored", 1'b1);
        check("t5b_queue_empty", 32'(exp_q[0].size()), 32'd0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        flush();
        check_quiet("t5b_clear", 1'b0);

        // Asynchronous reset during row 2, then a fresh stream from row 0.
        ready = 1'b1;
        load_col({16'd8, 16'd7, 16'd6, 16'd5});
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_pre_valid", 32'(valid_a), 32'd1);
        rstn = 1'b0;
        #1;
        check_quiet("t6_async", 1'b0);
        flush();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        load_col({16'hFFFF, 16'h0013, 16'h8003, 16'h7FFE});
        drain("t6_after", 16'h0000, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
